// File: rtl/d8m_onchip_mem_master_if.sv
// d8m_onchip_mem_master_if
// Groups the signals of the on-chip memory master: the block command port,
// status pulses, the write-data sink, the read-data source and the Avalon-MM
// connection to the single-port RAM. The "master" modport is the memory
// master's own view; the "slave" modport is the view of everything around it
// (command issuer, data producer/consumer and the RAM).
interface d8m_onchip_mem_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    // Command port
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    // Status
    logic              busy;
    logic              done;
    logic              err;

    // Write-data sink
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_be;
    logic              wr_valid;
    logic              wr_ready;

    // Read-data source
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    // Avalon-MM RAM port
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready, busy, done, err,
        input  wr_data, wr_be, wr_valid,
        output wr_ready,
        output rd_data, rd_valid,
        input  rd_ready,
        output avm_address, avm_byteenable, avm_chipselect, avm_write,
               avm_writedata,
        input  avm_readdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready, busy, done, err,
        output wr_data, wr_be, wr_valid,
        input  wr_ready,
        input  rd_data, rd_valid,
        output rd_ready,
        input  avm_address, avm_byteenable, avm_chipselect, avm_write,
               avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/d8m_onchip_mem_master.sv
// d8m_onchip_mem_master
// Avalon-MM master for the D8M single-port 32-bit on-chip RAM. A command
// (start word address, word count, direction) launches either a block read,
// whose words stream out of a 4-deep FIFO through a valid/ready source, or a
// block write, which takes words from a valid/ready sink and issues one
// registered RAM write per accepted beat. The RAM has a fixed one-cycle read
// latency and no waitrequest, so reads are throttled purely by counting: a
// read is only issued when the FIFO is guaranteed to have room for it.
//
// Optional feature macro: D8M_MEMMASTER_ADDR_WRAP_EN
//   defined   - no range check (err tied low); addresses wrap from DEPTH-1
//               to 0 so the RAM behaves as a circular buffer.
//   undefined - commands whose cmd_addr + cmd_len exceeds DEPTH are rejected
//               with a one-cycle err pulse and never touch the RAM.
module d8m_onchip_mem_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 45000,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    d8m_onchip_mem_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DRAIN,
        WR,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    // Address of the next access to issue, and accesses still to issue
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0]  remaining;

    // Registered Avalon-MM outputs
    logic [ADDR_W-1:0] avm_address_q;
    logic [3:0]        avm_be_q;
    logic              avm_cs_q;
    logic              avm_write_q;
    logic [DATA_W-1:0] avm_wdata_q;

    // A read was on the bus last cycle, so avm_readdata is valid this cycle
    logic              rd_pend;

    // Output FIFO
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_count;

    logic              done_q;
    logic              err_q;

    logic              cmd_fire;
    logic              len_zero;
    logic              range_ok;
    logic              start_rd;
    logic              start_wr;
    logic              rd_on_bus;
    logic [1:0]        in_flight;
    logic [2:0]        occupancy;
    logic              issue_rd;
    logic              wr_ready_i;
    logic              wr_beat;
    logic              rd_valid_i;
    logic              push;
    logic              pop;
    logic              drain_empty;

`ifdef D8M_MEMMASTER_ADDR_WRAP_EN
    // Circular-buffer addressing: step past the last RAM word back to 0
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    assign range_ok = 1'b1;
`else
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    logic [SUM_W-1:0] range_end;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    // The block must end at or before the last RAM word; the sum is one bit
    // wider than either operand so it cannot overflow.
    assign range_end = SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len);
    assign range_ok  = (range_end <= SUM_W'(DEPTH));
`endif

    assign cmd_fire = (state == IDLE) && bus.cmd_valid;
    assign len_zero = (bus.cmd_len == '0);
    assign start_rd = cmd_fire && !len_zero && range_ok && !bus.cmd_write;
    assign start_wr = cmd_fire && !len_zero && range_ok &&  bus.cmd_write;

    // Every issued read eventually lands in the FIFO, so reads on the bus and
    // reads whose data is arriving both count against FIFO space.
    assign rd_on_bus = avm_cs_q && !avm_write_q;
    assign in_flight = {1'b0, rd_on_bus} + {1'b0, rd_pend};
    assign occupancy = fifo_count + {1'b0, in_flight};

    // The first read is issued straight from IDLE so it reaches the bus in
    // the cycle after the command is accepted.
    assign issue_rd = start_rd ||
                      ((state == RD) && (remaining != '0) && (occupancy < 3'd4));

    assign wr_ready_i = (state == WR) && (remaining != '0);
    assign wr_beat    = wr_ready_i && bus.wr_valid;

    assign rd_valid_i = (fifo_count != 3'd0);
    assign push       = rd_pend;
    assign pop        = rd_valid_i && bus.rd_ready;

    // The last word leaves the FIFO this cycle with nothing left in flight
    assign drain_empty = (in_flight == 2'd0) &&
                         ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && pop));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_rd) begin
                    state_nx = RD;
                end else if (start_wr) begin
                    state_nx = WR;
                end
            end
            RD: begin
                if ((remaining == '0) || (issue_rd && (remaining == LEN_W'(1)))) begin
                    state_nx = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (drain_empty) begin
                    state_nx = DONE;
                end
            end
            WR: begin
                if (remaining == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address/count tracking and the registered RAM strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_addr     <= '0;
            remaining     <= '0;
            avm_address_q <= '0;
            avm_be_q      <= '0;
            avm_cs_q      <= 1'b0;
            avm_write_q   <= 1'b0;
            avm_wdata_q   <= '0;
        end else begin
            avm_cs_q    <= 1'b0;
            avm_write_q <= 1'b0;
            if (start_rd) begin
                avm_cs_q      <= 1'b1;
                avm_address_q <= bus.cmd_addr;
                avm_be_q      <= 4'hF;
                next_addr     <= addr_inc(bus.cmd_addr);
                remaining     <= bus.cmd_len - LEN_W'(1);
            end else if (start_wr) begin
                next_addr <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (issue_rd) begin
                avm_cs_q      <= 1'b1;
                avm_address_q <= next_addr;
                avm_be_q      <= 4'hF;
                next_addr     <= addr_inc(next_addr);
                remaining     <= remaining - LEN_W'(1);
            end else if (wr_beat) begin
                avm_cs_q      <= 1'b1;
                avm_write_q   <= 1'b1;
                avm_address_q <= next_addr;
                avm_be_q      <= bus.wr_be;
                avm_wdata_q   <= bus.wr_data;
                next_addr     <= addr_inc(next_addr);
                remaining     <= remaining - LEN_W'(1);
            end
        end
    end

    // Read-return tracking and FIFO pointers; reset flushes the FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_pend <= rd_on_bus;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};
        end
    end

    // FIFO storage captures the RAM read data one cycle after the read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.avm_readdata;
        end
    end

    // One-cycle completion pulse, also used for zero-length commands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_nx == DONE) || (cmd_fire && len_zero);
        end
    end

`ifdef D8M_MEMMASTER_ADDR_WRAP_EN
    assign err_q = 1'b0;
`else
    // One-cycle pulse for a command rejected by the range check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_fire && !len_zero && !range_ok;
        end
    end
`endif

    assign bus.cmd_ready      = (state == IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.wr_ready       = wr_ready_i;
    assign bus.rd_valid       = rd_valid_i;
    assign bus.rd_data        = fifo_mem[rd_ptr];
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_byteenable = avm_be_q;
    assign bus.avm_chipselect = avm_cs_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_writedata  = avm_wdata_q;

endmodule

// File: tb/tb_d8m_onchip_mem_master.sv
// tb_d8m_onchip_mem_master
// Scoreboard bench: each directed command pushes its expected RAM accesses,
// read words and done/err pulses (with expected cycle numbers) into queues;
// a negedge monitor pops and compares whenever the DUT presents an output.
// A behavioural RAM with one-cycle read latency answers the Avalon-MM port.
module tb_d8m_onchip_mem_master;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 45000;
    localparam int LEN_W  = 16;

    typedef struct {
        bit          wr;
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          cyc;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_t;

    typedef struct {
        bit is_err;
        int cyc;
    } evt_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   outstanding;
    int   rd_mode;
    int   rd_phase;

    acc_t        exp_acc[$];
    rd_t         exp_rd[$];
    evt_t        exp_evt[$];
    logic [31:0] wr_words[$];
    logic [31:0] ram [0:DEPTH-1];

    d8m_onchip_mem_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    d8m_onchip_mem_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: byte-lane writes, one-cycle read latency
    always @(posedge clk) begin
        if (bus.avm_chipselect) begin
            if (bus.avm_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.avm_byteenable[b]) begin
                        ram[int'(bus.avm_address)][8*b +: 8] <= bus.avm_writedata[8*b +: 8];
                    end
                end
            end else begin
                bus.avm_readdata <= ram[int'(bus.avm_address)];
            end
        end
    end

    // rd_ready pattern: always 1, or the repeating 1,0,0 stall pattern
    always @(posedge clk) begin
        #1;
        if (rd_mode == 0) begin
            bus.rd_ready = 1'b1;
        end else begin
            bus.rd_ready = (rd_phase == 0);
            rd_phase     = (rd_phase == 2) ? 0 : rd_phase + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_access(input bit wr, input int addr, input logic [31:0] data,
                              input logic [3:0] be, input int c);
        acc_t a;
        a.wr = wr; a.addr = addr; a.data = data; a.be = be; a.cyc = c;
        exp_acc.push_back(a);
    endtask

    task automatic exp_read(input logic [31:0] data, input int c);
        rd_t r;
        r.data = data; r.cyc = c;
        exp_rd.push_back(r);
    endtask

    task automatic exp_event(input bit is_err, input int c);
        evt_t e;
        e.is_err = is_err; e.cyc = c;
        exp_evt.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    always @(negedge clk) begin
        acc_t a;
        rd_t  r;
        evt_t e;
        if (!reset_n) begin
            outstanding = 0;
        end else begin
            if (bus.avm_chipselect) begin
                if (!bus.avm_write) begin
                    outstanding++;
                    check_output("occupancy_le_4", 32'(outstanding <= 4), 32'd1);
                end
                if (exp_acc.size() == 0) begin
                    check_output("unexpected_access_addr", 32'(bus.avm_address), 32'hFFFF_FFFF);
                end else begin
                    a = exp_acc.pop_front();
                    check_output("acc_write", 32'(bus.avm_write), 32'(a.wr));
                    check_output("acc_addr", 32'(bus.avm_address), a.addr);
                    check_output("acc_be", 32'(bus.avm_byteenable), 32'(a.be));
                    if (a.wr) check_output("acc_wdata", bus.avm_writedata, a.data);
                    if (a.cyc >= 0) check_output("acc_cycle", cyc, a.cyc);
                end
            end
            if (bus.rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check_output("unexpected_rd_valid", bus.rd_data, 32'hxxxx_xxxx);
                end else if (bus.rd_ready) begin
                    r = exp_rd.pop_front();
                    check_output("rd_data", bus.rd_data, r.data);
                    if (r.cyc >= 0) check_output("rd_cycle", cyc, r.cyc);
                    outstanding--;
                end else begin
                    check_output("rd_data_stalled", bus.rd_data, exp_rd[0].data);
                end
            end
            if (bus.done || bus.err) begin
                if (exp_evt.size() == 0) begin
                    check_output("unexpected_done_err", {30'd0, bus.err, bus.done}, 32'd0);
                end else begin
                    e = exp_evt.pop_front();
                    check_output("evt_done", 32'(bus.done), 32'(!e.is_err));
                    check_output("evt_err", 32'(bus.err), 32'(e.is_err));
                    if (e.cyc >= 0) check_output("evt_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Drive a command in the current cycle; c0 is that cycle's number
    task automatic apply_stimulus(input bit wr, input int addr, input int len,
                                  input logic [3:0] be, output int c0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = ADDR_W'(addr);
        bus.cmd_len   = LEN_W'(len);
        bus.wr_be     = be;
        if (wr && len > 0) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wr_words[0];
        end
        c0 = cyc;
    endtask

    // Retire the command and feed write beats, wr_valid held high
    task automatic feed_write(input int len);
        int idx;
        bit hs;
        idx = 0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int t = 0; t < 200 && idx < len; t++) begin
            @(negedge clk);
            hs = bus.wr_valid && bus.wr_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < len) bus.wr_data = wr_words[idx];
                else           bus.wr_valid = 1'b0;
            end
        end
        bus.wr_valid = 1'b0;
        if (len > 0) check_output("write_beats_accepted", idx, len);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && exp_acc.size() == 0 && exp_rd.size() == 0 &&
                exp_evt.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("idle_reached", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        cyc = 0; vectors = 0; miscompares = 0; outstanding = 0;
        rd_mode = 0; rd_phase = 0;
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_data   = '0;
        bus.wr_be     = 4'hF;
        bus.wr_valid  = 1'b0;
        bus.rd_ready  = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_chipselect", 32'(bus.avm_chipselect), 32'd0);
        check_output("rst_write", 32'(bus.avm_write), 32'd0);
        check_output("rst_address", 32'(bus.avm_address), 32'd0);
        check_output("rst_byteenable", 32'(bus.avm_byteenable), 32'd0);
        check_output("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        check_output("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Block write 100..103, done one cycle after the last write
        wr_words = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        apply_stimulus(1'b1, 100, 4, 4'hF, c0);
        for (int i = 0; i < 4; i++) exp_access(1'b1, 100 + i, wr_words[i], 4'hF, c0 + 2 + i);
        exp_event(1'b0, c0 + 6);
        feed_write(4);
        wait_idle();

        // Block read 100..103: accesses cycles 1-4, rd_valid 3-6, done 7
        apply_stimulus(1'b0, 100, 4, 4'hF, c0);
        for (int i = 0; i < 4; i++) begin
            exp_access(1'b0, 100 + i, '0, 4'hF, c0 + 1 + i);
            exp_read(wr_words[i], c0 + 3 + i);
        end
        exp_event(1'b0, c0 + 7);
        feed_write(0);
        wait_idle();

        // Zero length: done in cycle 1, no RAM access
        apply_stimulus(1'b0, 50, 0, 4'hF, c0);
        exp_event(1'b0, c0 + 1);
        feed_write(0);
        wait_idle();

`ifdef D8M_MEMMASTER_ADDR_WRAP_EN
        // Wrapping block: 44998, 44999, 0
        wr_words = {32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
        apply_stimulus(1'b1, 44998, 3, 4'hF, c0);
        exp_access(1'b1, 44998, 32'hC0DE_0001, 4'hF, c0 + 2);
        exp_access(1'b1, 44999, 32'hC0DE_0002, 4'hF, c0 + 3);
        exp_access(1'b1, 0,     32'hC0DE_0003, 4'hF, c0 + 4);
        exp_event(1'b0, c0 + 5);
        feed_write(3);
        wait_idle();
`else
        // Out of range: err in cycle 1, no RAM access
        apply_stimulus(1'b0, 44998, 3, 4'hF, c0);
        exp_event(1'b1, c0 + 1);
        feed_write(0);
        wait_idle();
`endif

        // Block ending exactly at the last RAM word is legal
        wr_words = {32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
        apply_stimulus(1'b1, 44997, 3, 4'hF, c0);
        for (int i = 0; i < 3; i++) exp_access(1'b1, 44997 + i, wr_words[i], 4'hF, c0 + 2 + i);
        exp_event(1'b0, c0 + 5);
        feed_write(3);
        wait_idle();

        // Partial byte enables: full write, then lanes 0 and 2, then read back
        wr_words = {32'hAAAA_AAAA, 32'hBBBB_BBBB};
        apply_stimulus(1'b1, 300, 2, 4'hF, c0);
        for (int i = 0; i < 2; i++) exp_access(1'b1, 300 + i, wr_words[i], 4'hF, c0 + 2 + i);
        exp_event(1'b0, c0 + 4);
        feed_write(2);
        wait_idle();
        wr_words = {32'h1122_3344, 32'h5566_7788};
        apply_stimulus(1'b1, 300, 2, 4'b0101, c0);
        for (int i = 0; i < 2; i++) exp_access(1'b1, 300 + i, wr_words[i], 4'b0101, c0 + 2 + i);
        exp_event(1'b0, c0 + 4);
        feed_write(2);
        wait_idle();
        apply_stimulus(1'b0, 300, 2, 4'hF, c0);
        exp_access(1'b0, 300, '0, 4'hF, c0 + 1);
        exp_access(1'b0, 301, '0, 4'hF, c0 + 2);
        exp_read(32'hAA22_AA44, c0 + 3);
        exp_read(32'hBB66_BB88, c0 + 4);
        exp_event(1'b0, c0 + 5);
        feed_write(0);
        wait_idle();

        // Eight words at 200, then read them back with rd_ready 1,0,0,...
        wr_words = {};
        for (int i = 0; i < 8; i++) wr_words.push_back(32'h5A5A_0000 | 32'(i));
        apply_stimulus(1'b1, 200, 8, 4'hF, c0);
        for (int i = 0; i < 8; i++) exp_access(1'b1, 200 + i, wr_words[i], 4'hF, c0 + 2 + i);
        exp_event(1'b0, c0 + 10);
        feed_write(8);
        wait_idle();
        rd_phase = 0;
        rd_mode  = 1;
        apply_stimulus(1'b0, 200, 8, 4'hF, c0);
        for (int i = 0; i < 8; i++) begin
            exp_access(1'b0, 200 + i, '0, 4'hF, -1);
            exp_read(wr_words[i], -1);
        end
        exp_event(1'b0, -1);
        feed_write(0);
        wait_idle();
        rd_mode = 0;

        // Reset during the third read of an eight-word block
        apply_stimulus(1'b0, 200, 8, 4'hF, c0);
        for (int i = 0; i < 3; i++) exp_access(1'b0, 200 + i, '0, 4'hF, c0 + 1 + i);
        exp_read(wr_words[0], c0 + 3);
        feed_write(0);
        repeat (3) @(negedge clk);
        check_output("cs_before_reset", 32'(bus.avm_chipselect), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midrst_chipselect", 32'(bus.avm_chipselect), 32'd0);
        check_output("midrst_write", 32'(bus.avm_write), 32'd0);
        check_output("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_output("midrst_busy", 32'(bus.busy), 32'd0);
        check_output("midrst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(negedge clk);
        check_output("postrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (6) @(negedge clk);
        check_output("postrst_busy", 32'(bus.busy), 32'd0);

        check_output("acc_queue_empty", exp_acc.size(), 32'd0);
        check_output("rd_queue_empty", exp_rd.size(), 32'd0);
        check_output("evt_queue_empty", exp_evt.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
